// File: rtl/uart_pixel_loader.sv
// 8N1 serial receiver that turns each byte into either a frame-start command
// or a pixel write strobe for the panel driver's pixel store.
module uart_pixel_loader #(
  parameter int CLOCK_RATE = 1000,
  parameter int BAUD_RATE  = 125,
  parameter int NUM_PIXELS = 128,
  parameter int ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_rgb,
  output logic              frame_start,
  output logic              frame_done,
  output logic              framing_err,
  output logic              busy
);

  localparam int CPB   = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_q;
  logic              meta_q;
  logic              sync_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [2:0]        bitIdx_q;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic              busy_q;
  logic              framingErr_q;
  logic              wrEn_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [2:0]        wrRgb_q;
  logic              frameStart_q;
  logic              frameDone_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              ptrLast;
  logic              cntLast;
  logic              accept;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= uart_data;
      sync_q <= meta_q;
    end
  end

  assign cnt_d   = cnt_q + CNT_W'(1);
  assign cntLast = (cnt_q == CNT_LAST);
  assign shift_d = {sync_q, shift_q[7:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      framingErr_q <= 1'b0;
    end else begin
      framingErr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sync_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!sync_q) begin
              state_q  <= S_DATA;
              bitIdx_q <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          if (cntLast) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bitIdx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_STOP: begin
          if (cntLast) begin
            cnt_q <= '0;
            if (sync_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q      <= S_BREAK;
              framingErr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_BREAK: begin
          if (sync_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign accept  = (state_q == S_STOP) && cntLast && sync_q;
  assign ptrLast = (ptr_q == PTR_LAST);
  assign ptr_d   = ptrLast ? '0 : ptr_q + ADDR_W'(1);

  // Decoder fires in the cycle after a good stop-bit sample; shift_q is complete then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrRgb_q      <= '0;
      frameStart_q <= 1'b0;
      frameDone_q  <= 1'b0;
      ptr_q        <= '0;
    end else begin
      wrEn_q       <= 1'b0;
      frameStart_q <= 1'b0;
      frameDone_q  <= 1'b0;
      if (accept) begin
        if (shift_q[7]) begin
          ptr_q        <= '0;
          frameStart_q <= 1'b1;
        end else begin
          wrEn_q      <= 1'b1;
          wrAddr_q    <= ptr_q;
          wrRgb_q     <= shift_q[2:0];
          frameDone_q <= ptrLast;
          ptr_q       <= ptr_d;
        end
      end
    end
  end

  assign wr_en       = wrEn_q;
  assign wr_addr     = wrAddr_q;
  assign wr_rgb      = wrRgb_q;
  assign frame_start = frameStart_q;
  assign frame_done  = frameDone_q;
  assign framing_err = framingErr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader: serial bytes in, pixel writes
// compared against a frame/pointer model of the decoder.
module tb_uart_pixel_loader;

  localparam int CPB        = 8;
  localparam int NUM_PIXELS = 128;
  localparam int ADDR_W     = 7;
  localparam int WR_W       = 1 + ADDR_W + 3;

  logic              clk;
  logic              rst_n;
  logic              uartData;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_rgb;
  logic              frame_start;
  logic              frame_done;
  logic              framing_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Observed traffic, written by the monitor; entries are {frame_done, addr, rgb}.
  logic [WR_W-1:0] obsW[$];
  int obsStarts;
  int obsErrs;
  int obsStrayDone;
  int busyCycles;

  // Reference model: pointer and the expected write/command stream.
  logic [WR_W-1:0] expW[$];
  int expStarts;
  int modelPtr;

  uart_pixel_loader #(
    .CLOCK_RATE(1000),
    .BAUD_RATE (125),
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_data  (uartData),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_rgb     (wr_rgb),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .framing_err(framing_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) obsW.push_back({frame_done, wr_addr, wr_rgb});
    if (frame_start) obsStarts++;
    if (framing_err) obsErrs++;
    if (frame_done && !wr_en) obsStrayDone++;
    if (busy) busyCycles++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearObs();
    obsW.delete();
    expW.delete();
    obsStarts    = 0;
    obsErrs      = 0;
    obsStrayDone = 0;
    expStarts    = 0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uartData = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uartData = 1'b1;
  endtask

  // A good byte is either a start command (pointer back to 0) or a pixel at the pointer.
  task automatic modelByte(input logic [7:0] b);
    if (b[7]) begin
      modelPtr = 0;
      expStarts++;
    end else begin
      expW.push_back({(modelPtr == NUM_PIXELS - 1), ADDR_W'(modelPtr), b[2:0]});
      modelPtr = (modelPtr + 1) % NUM_PIXELS;
    end
  endtask

  task automatic sendGood(input logic [7:0] b);
    sendByte(b, 1'b1);
    modelByte(b);
  endtask

  task automatic test_reset();
    uartData = 1'b1;
    rst_n    = 1'b0;
    idle(3);
    checks++;
    if (wr_en !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 || framing_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset.pulses: got %b%b%b%b expected 0000", wr_en, frame_start, frame_done, framing_err);
    end
    checks++;
    if (wr_addr !== '0 || wr_rgb !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset.addr_rgb: got addr=%0d rgb=%0d expected 0 0", wr_addr, wr_rgb);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset.busy: got %b expected 0", busy);
    end
    rst_n    = 1'b1;
    modelPtr = 0;
    idle(4);
  endtask

  task automatic test_single_pixel();
    clearObs();
    busyCycles = 0;
    sendGood(8'h05);
    idle(20);
    checks++;
    if (obsW.size() !== expW.size()) begin
      errors++;
      $display("[TB] FAIL single.count: got %0d expected %0d", obsW.size(), expW.size());
    end
    for (int i = 0; i < expW.size() && i < obsW.size(); i++) begin
      checks++;
      if (obsW[i] !== expW[i]) begin
        errors++;
        $display("[TB] FAIL single.write[%0d]: got %h expected %h", i, obsW[i], expW[i]);
      end
    end
    checks++;
    if (obsStarts !== 0 || obsErrs !== 0) begin
      errors++;
      $display("[TB] FAIL single.flags: got starts=%0d errs=%0d expected 0 0", obsStarts, obsErrs);
    end
    checks++;
    if (busyCycles !== 76) begin
      errors++;
      $display("[TB] FAIL single.busy: got %0d cycles expected 76", busyCycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[6];
    seq = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h83, 8'h07};
    clearObs();
    foreach (seq[i]) sendGood(seq[i]);
    idle(20);
    checks++;
    if (obsW.size() !== expW.size()) begin
      errors++;
      $display("[TB] FAIL b2b.count: got %0d expected %0d", obsW.size(), expW.size());
    end
    for (int i = 0; i < expW.size() && i < obsW.size(); i++) begin
      checks++;
      if (obsW[i] !== expW[i]) begin
        errors++;
        $display("[TB] FAIL b2b.write[%0d]: got %h expected %h", i, obsW[i], expW[i]);
      end
    end
    checks++;
    if (obsStarts !== expStarts) begin
      errors++;
      $display("[TB] FAIL b2b.starts: got %0d expected %0d", obsStarts, expStarts);
    end
  endtask

  task automatic test_full_frame();
    int doneSeen;
    clearObs();
    sendGood(8'h80);
    for (int i = 0; i < NUM_PIXELS; i++) sendGood(8'(i % 8));
    sendGood(8'h06);
    idle(20);
    checks++;
    if (obsW.size() !== expW.size()) begin
      errors++;
      $display("[TB] FAIL frame.count: got %0d expected %0d", obsW.size(), expW.size());
    end
    for (int i = 0; i < expW.size() && i < obsW.size(); i++) begin
      checks++;
      if (obsW[i] !== expW[i]) begin
        errors++;
        $display("[TB] FAIL frame.write[%0d]: got %h expected %h", i, obsW[i], expW[i]);
      end
    end
    doneSeen = 0;
    foreach (obsW[i]) if (obsW[i][WR_W-1]) doneSeen++;
    checks++;
    if (doneSeen !== 1 || obsStrayDone !== 0) begin
      errors++;
      $display("[TB] FAIL frame.done: got %0d with write, %0d stray expected 1, 0", doneSeen, obsStrayDone);
    end
    checks++;
    if (obsStarts !== 1) begin
      errors++;
      $display("[TB] FAIL frame.starts: got %0d expected 1", obsStarts);
    end
  endtask

  task automatic test_framing_error();
    clearObs();
    sendByte(8'h55, 1'b0);
    uartData = 1'b0;
    idle(20 * CPB);
    uartData = 1'b1;
    idle(20);
    sendGood(8'h03);
    idle(20);
    checks++;
    if (obsErrs !== 1) begin
      errors++;
      $display("[TB] FAIL ferr.pulses: got %0d expected 1", obsErrs);
    end
    checks++;
    if (obsW.size() !== expW.size()) begin
      errors++;
      $display("[TB] FAIL ferr.count: got %0d expected %0d", obsW.size(), expW.size());
    end
    for (int i = 0; i < expW.size() && i < obsW.size(); i++) begin
      checks++;
      if (obsW[i] !== expW[i]) begin
        errors++;
        $display("[TB] FAIL ferr.write[%0d]: got %h expected %h", i, obsW[i], expW[i]);
      end
    end
  endtask

  task automatic test_glitch();
    clearObs();
    busyCycles = 0;
    uartData = 1'b0;
    idle(2);
    uartData = 1'b1;
    idle(30);
    checks++;
    if (busyCycles < 1 || busyCycles > CPB) begin
      errors++;
      $display("[TB] FAIL glitch.busy: got %0d cycles expected 1..%0d", busyCycles, CPB);
    end
    checks++;
    if (obsW.size() !== 0 || obsStarts !== 0 || obsErrs !== 0) begin
      errors++;
      $display("[TB] FAIL glitch.quiet: got writes=%0d starts=%0d errs=%0d expected 0 0 0", obsW.size(), obsStarts, obsErrs);
    end
    sendGood(8'h02);
    idle(20);
    checks++;
    if (obsW.size() !== 1 || (obsW.size() == 1 && obsW[0] !== expW[0])) begin
      errors++;
      $display("[TB] FAIL glitch.next: got %0d writes first=%h expected 1 write %h", obsW.size(), (obsW.size() > 0) ? obsW[0] : '0, expW[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] partial;
    clearObs();
    for (int i = 0; i < 10; i++) sendGood(8'($urandom_range(0, 127)));
    partial = {1'b1, 8'h07, 1'b0};
    for (int i = 0; i < 5; i++) begin
      uartData = partial[i];
      idle(CPB);
    end
    idle(CPB / 2);
    rst_n    = 1'b0;
    uartData = 1'b1;
    idle(1);
    rst_n    = 1'b1;
    modelPtr = 0;
    checks++;
    if (wr_addr !== '0 || wr_en !== 1'b0 || busy !== 1'b0 || wr_rgb !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rstmid.outputs: got addr=%0d en=%b busy=%b rgb=%0d expected 0 0 0 0", wr_addr, wr_en, busy, wr_rgb);
    end
    checks++;
    if (obsW.size() !== expW.size()) begin
      errors++;
      $display("[TB] FAIL rstmid.before: got %0d writes expected %0d", obsW.size(), expW.size());
    end
    idle(100);
    clearObs();
    sendGood(8'h01);
    idle(20);
    checks++;
    if (obsW.size() !== 1 || (obsW.size() == 1 && obsW[0] !== expW[0])) begin
      errors++;
      $display("[TB] FAIL rstmid.after: got %0d writes first=%h expected 1 write %h", obsW.size(), (obsW.size() > 0) ? obsW[0] : '0, expW[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    clearObs();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 7) != 0) b[7] = 1'b0;
      sendGood(b);
      idle($urandom_range(0, 3));
    end
    idle(20);
    checks++;
    if (obsW.size() !== expW.size()) begin
      errors++;
      $display("[TB] FAIL random.count: got %0d expected %0d", obsW.size(), expW.size());
    end
    for (int i = 0; i < expW.size() && i < obsW.size(); i++) begin
      checks++;
      if (obsW[i] !== expW[i]) begin
        errors++;
        $display("[TB] FAIL random.write[%0d]: got %h expected %h", i, obsW[i], expW[i]);
      end
    end
    checks++;
    if (obsStarts !== expStarts || obsErrs !== 0) begin
      errors++;
      $display("[TB] FAIL random.flags: got starts=%0d errs=%0d expected %0d 0", obsStarts, obsErrs, expStarts);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    uartData = 1'b1;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_full_frame();
    test_framing_error();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
Upstream feeder for the single-panel LED driver.
- Receives 8N1 serial bytes on the uart_data pin.
- Decodes each byte as either a frame-start command or an RGB pixel value.
- Emits one-cycle write strobes (address + 3-bit colour) into the panel driver's pixel store.
- Sits between the chip's dedicated input ui_in[0] and the panel driver's pixel write port.

Parameters:
- CLOCK_RATE, 1000, system clock frequency in Hz.
- BAUD_RATE, 125, serial bit rate in Hz. CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE must be an integer ≥4 (default 8).
- NUM_PIXELS, 128, pixels per frame (4 rows × 32 columns).
- ADDR_W, 7, pixel address width; must satisfy 2^ADDR_W ≥ NUM_PIXELS.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- uart_data  input  1  asynchronous serial line; idles high.
- wr_en  output  1  one-cycle pixel write strobe.
- wr_addr  output  ADDR_W  pixel address; valid while wr_en is high.
- wr_rgb  output  3  colour {B,G,R} = byte[2:0]; valid while wr_en is high.
- frame_start  output  1  one-cycle pulse when a start command is accepted.
- frame_done  output  1  one-cycle pulse coincident with the write to address NUM_PIXELS-1.
- framing_err  output  1  one-cycle pulse on a bad stop bit.
- busy  output  1  high while the receiver is not in IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0; wr_addr 0; pixel pointer 0.
  - Receiver goes to IDLE; synchroniser flops set to 1.
  - Reset mid-byte or mid-frame abandons that byte or frame with no write.
- Input conditioning: uart_data passes through a 2-flop synchroniser (sync_q). All decisions use sync_q.
- Receiver FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when sync_q==0, go to START with bit counter cnt=0.
  - START: cnt increments each clock. At cnt==CLKS_PER_BIT/2-1, sample sync_q.
    - Sample 0: go to DATA, cnt=0, bit index=0.
    - Sample 1: glitch; return to IDLE with no output.
  - DATA: sample sync_q at cnt==CLKS_PER_BIT-1, shift in LSB first, reset cnt. After the 8th sample, go to STOP.
  - STOP: sample at cnt==CLKS_PER_BIT-1.
    - Sample 1: byte accepted; go to IDLE.
    - Sample 0: framing_err pulses on the next cycle, byte discarded, go to BREAK.
  - BREAK: wait until sync_q==1, then go to IDLE. No start detection while in BREAK.
- busy: equals (state != IDLE), registered.
- Decoder (acts on an accepted byte; outputs registered):
  - Outputs are valid in the cycle after the stop-bit sample.
  - Latency from the line's rising edge at the stop-bit centre is 3 clocks including synchroniser.
  - byte[7]==1: pointer←0, frame_start=1, no write. byte[6:0] ignored.
  - byte[7]==0: wr_en=1, wr_addr=pointer, wr_rgb=byte[2:0]. byte[6:3] ignored.
    - Pointer increments, wrapping to 0 after NUM_PIXELS-1.
    - On that wrap, frame_done=1 in the same cycle as wr_en.
  - A pixel after the wrap writes address 0. No start command is needed between consecutive frames.
- Pulse and hold rules:
  - wr_en, frame_start, frame_done and framing_err are each high for exactly one cycle per event.
  - Never more than one byte event per CLKS_PER_BIT×10 clocks, so events never collide.
  - wr_addr and wr_rgb hold their last values when wr_en is low.
- Back-to-back bytes: a start bit arriving immediately after a valid stop-bit sample (line low on the next cycle) is detected from IDLE with no lost byte.

Test Plan:
1. Reset, then send 0x05 at CLKS_PER_BIT=8 → single wr_en with wr_addr=0, wr_rgb=3'b101. frame_start=0, framing_err=0. busy high for 76 clocks.
2. Send 0x80, then 0x01, 0x02, 0x04 → frame_start pulse; writes at addr 0,1,2 with rgb 1,2,4. Then send 0x83 → frame_start; next pixel 0x07 writes addr 0.
3. Send 128 pixel bytes 0x00..0x07 cycling, followed by 0x06 → the 128th write has addr 127 with frame_done=1 in the same cycle. The 129th write has addr 0, frame_done=0.
4. Send 0x55 with stop bit forced low, hold the line low 20 bit times, then release and send 0x03 → one framing_err pulse, no wr_en for 0x55. After release, write of rgb 3 at the unchanged pointer.
5. Apply a 2-clock low glitch on an idle line → busy pulses briefly, returns to IDLE, no outputs. Next valid byte 0x02 decodes correctly.
6. Assert rst_n low for 1 clock midway through the data bits of 0x07 after 10 pixels → all outputs 0, pointer 0. The partial byte is never written; the following byte 0x01 writes addr 0.
